iic_key_ctrl: RTL



---
 rtl/iic_key_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/iic_key_ctrl.sv
// iic_key_ctrl: front-end command stage for the IIC byte read/write controller.
// Debounces three raw push-buttons (write, read, data-increment), holds the
// byte to be written and issues fixed-width active-low key_wr / key_rd strobes,
// each followed by a lockout window during which new commands are dropped.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   btn_wr_n   raw write button, active-low, asynchronous
//   btn_rd_n   raw read button, active-low, asynchronous
//   btn_inc_n  raw increment button, active-low, asynchronous
//   key_wr     active-low write command (registered)
//   key_rd     active-low read command (registered)
//   data_in    byte presented for writes (registered)
//   busy       high while a strobe or lockout is in progress (registered)

// Per-button synchronizer, debouncer and press detector.
// press is a registered one-cycle pulse on a debounced 1->0 transition.
module iic_key_deb #(
    parameter int DEB_CNT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);
    localparam int DW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          lvl_q, lvl_d;
    logic          armed_q, armed_d;
    logic          press_q, press_d;
    logic [1:0]    fill_q, fill_d;
    logic [DW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_n;
        sync2_d = sync1_q;
        // fill_q[1] marks that sync2_q now reflects the pin, not its reset value.
        fill_d  = {fill_q[0], 1'b1};
        // Presses are only honoured once the button has been seen released
        // after reset, so a button held through reset release does nothing.
        armed_d = armed_q | (fill_q[1] & sync2_q);
        lvl_d   = lvl_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (sync2_q != lvl_q) begin
            if (cnt_q == DEB_LAST) begin
                lvl_d   = sync2_q;
                cnt_d   = '0;
                press_d = ~sync2_q & armed_q;
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            lvl_q   <= 1'b1;
            armed_q <= 1'b0;
            press_q <= 1'b0;
            fill_q  <= 2'b00;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            lvl_q   <= lvl_d;
            armed_q <= armed_d;
            press_q <= press_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;
endmodule

module iic_key_ctrl #(
    parameter int DEB_CNT  = 1_000_000,
    parameter int STB_CNT  = 2_000,
    parameter int LOCK_CNT = 50_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_wr_n,
    input  logic       btn_rd_n,
    input  logic       btn_inc_n,
    output logic       key_wr,
    output logic       key_rd,
    output logic [7:0] data_in,
    output logic       busy
);
    localparam int SW = (STB_CNT > 1) ? $clog2(STB_CNT) : 1;
    localparam int LW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam int CW = (SW > LW) ? SW : LW;
    localparam logic [CW-1:0] STB_LAST  = CW'(STB_CNT - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CNT - 1);

    typedef enum logic [1:0] {IDLE, STROBE, LOCK} state_t;

    // Button index: 0 = write, 1 = read, 2 = increment.
    logic [2:0] btn_n_vec;
    logic [2:0] press;
    assign btn_n_vec = {btn_inc_n, btn_rd_n, btn_wr_n};

    for (genvar i = 0; i < 3; i++) begin : g_deb
        iic_key_deb #(.DEB_CNT(DEB_CNT)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .btn_n (btn_n_vec[i]),
            .press (press[i])
        );
    end

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          key_wr_q, key_wr_d;
    logic          key_rd_q, key_rd_d;
    logic          busy_q, busy_d;
    logic [7:0]    data_q, data_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        key_wr_d = key_wr_q;
        key_rd_d = key_rd_q;
        data_d   = data_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Increment and write may coincide; the strobe then carries
                // the incremented byte since data_d lands on the same edge.
                if (press[2]) data_d = data_q + 8'd1;
                if (press[0]) begin
                    state_d  = STROBE;
                    key_wr_d = 1'b0;
                end else if (press[1]) begin
                    state_d  = STROBE;
                    key_rd_d = 1'b0;
                end
            end
            STROBE: begin
                if (cnt_q == STB_LAST) begin
                    state_d  = LOCK;
                    cnt_d    = '0;
                    key_wr_d = 1'b1;
                    key_rd_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LOCK: begin
                if (cnt_q == LOCK_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            key_wr_q <= 1'b1;
            key_rd_q <= 1'b1;
            busy_q   <= 1'b0;
            data_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            key_wr_q <= key_wr_d;
            key_rd_q <= key_rd_d;
            busy_q   <= busy_d;
            data_q   <= data_d;
        end
    end

    assign key_wr  = key_wr_q;
    assign key_rd  = key_rd_q;
    assign data_in = data_q;
    assign busy    = busy_q;
endmodule
